// File: rtl/ising_bram_pkg.sv
// Shared constants and types for the Ising sampler BRAM port arbiter.
package ising_bram_pkg;
  localparam int DATA_W = 64;
  localparam int ADDR_W = 7;
  localparam int RD_LAT = 2;

  typedef enum logic {REQ_SPIN = 1'b0, REQ_HOST = 1'b1} req_id_t;

  typedef struct packed {
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } cmd_t;

  function automatic req_id_t other_req(input req_id_t id);
    return (id == REQ_SPIN) ? REQ_HOST : REQ_SPIN;
  endfunction
endpackage

// File: rtl/bram_rd_tag_pipe.sv
// Shift register of {valid, id} read tags; the last stage lines up with douta capture.
module bram_rd_tag_pipe
  import ising_bram_pkg::*;
#(
  parameter int DEPTH = RD_LAT + 1
) (
  input  logic    clock,
  input  logic    reset,
  input  logic    in_valid,
  input  req_id_t in_id,
  output logic    out_valid,
  output req_id_t out_id,
  output logic    any_valid
);

  logic [DEPTH-1:0] vld_q, vld_d;
  req_id_t          id_q [DEPTH];
  req_id_t          id_d [DEPTH];

  always_comb begin
    vld_d   = {vld_q[DEPTH-2:0], in_valid};
    id_d[0] = in_id;
    for (int i = 1; i < DEPTH; i++) begin
      id_d[i] = id_q[i-1];
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      vld_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        id_q[i] <= REQ_SPIN;
      end
    end else begin
      vld_q <= vld_d;
      for (int i = 0; i < DEPTH; i++) begin
        id_q[i] <= id_d[i];
      end
    end
  end

  assign out_valid = vld_q[DEPTH-1];
  assign out_id    = id_q[DEPTH-1];
  assign any_valid = |vld_q;

endmodule

// File: rtl/bram_port_arbiter.sv
// Round-robin arbiter sharing one single-port BRAM between the spin engine (req0)
// and the host loader (req1); read data is routed back by a fixed-latency tag pipe.
module bram_port_arbiter #(
  parameter int DATA_W = ising_bram_pkg::DATA_W,
  parameter int ADDR_W = ising_bram_pkg::ADDR_W,
  parameter int RD_LAT = ising_bram_pkg::RD_LAT
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic              req0_we,
  input  logic [ADDR_W-1:0] req0_addr,
  input  logic [DATA_W-1:0] req0_wdata,
  output logic              rsp0_valid,
  output logic [DATA_W-1:0] rsp0_rdata,
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic              req1_we,
  input  logic [ADDR_W-1:0] req1_addr,
  input  logic [DATA_W-1:0] req1_wdata,
  output logic              rsp1_valid,
  output logic [DATA_W-1:0] rsp1_rdata,
  output logic              bram_ena,
  output logic              bram_wea,
  output logic [ADDR_W-1:0] bram_addra,
  output logic [DATA_W-1:0] bram_dina,
  input  logic [DATA_W-1:0] bram_douta,
  output logic              busy
);
  import ising_bram_pkg::*;

  req_id_t           rr_q, rr_d;
  logic              ena_q, ena_d, wea_q, wea_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] din_q, din_d;
  logic              rsp0_valid_q, rsp0_valid_d, rsp1_valid_q, rsp1_valid_d;
  logic [DATA_W-1:0] rsp0_rdata_q, rsp0_rdata_d, rsp1_rdata_q, rsp1_rdata_d;

  logic              grant0, grant1, accept;
  req_id_t           win_id;
  logic              win_we;
  logic [ADDR_W-1:0] win_addr;
  logic [DATA_W-1:0] win_wdata;
  logic              tag_out_valid, tag_busy;
  req_id_t           tag_out_id;

  always_comb begin
    // A lone requester always wins; the pointer only breaks ties.
    grant0    = req0_valid & (~req1_valid | (rr_q == REQ_SPIN));
    grant1    = req1_valid & (~req0_valid | (rr_q == REQ_HOST));
    accept    = grant0 | grant1;
    win_id    = grant1 ? REQ_HOST : REQ_SPIN;
    win_we    = grant1 ? req1_we    : req0_we;
    win_addr  = grant1 ? req1_addr  : req0_addr;
    win_wdata = grant1 ? req1_wdata : req0_wdata;

    rr_d   = accept ? other_req(win_id) : rr_q;
    ena_d  = accept;
    wea_d  = accept & win_we;
    addr_d = accept ? win_addr  : addr_q;
    din_d  = accept ? win_wdata : din_q;

    rsp0_valid_d = tag_out_valid & (tag_out_id == REQ_SPIN);
    rsp1_valid_d = tag_out_valid & (tag_out_id == REQ_HOST);
    rsp0_rdata_d = rsp0_valid_d ? bram_douta : rsp0_rdata_q;
    rsp1_rdata_d = rsp1_valid_d ? bram_douta : rsp1_rdata_q;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rr_q         <= REQ_SPIN;
      ena_q        <= 1'b0;
      wea_q        <= 1'b0;
      addr_q       <= '0;
      din_q        <= '0;
      rsp0_valid_q <= 1'b0;
      rsp1_valid_q <= 1'b0;
      rsp0_rdata_q <= '0;
      rsp1_rdata_q <= '0;
    end else begin
      rr_q         <= rr_d;
      ena_q        <= ena_d;
      wea_q        <= wea_d;
      addr_q       <= addr_d;
      din_q        <= din_d;
      rsp0_valid_q <= rsp0_valid_d;
      rsp1_valid_q <= rsp1_valid_d;
      rsp0_rdata_q <= rsp0_rdata_d;
      rsp1_rdata_q <= rsp1_rdata_d;
    end
  end

  // One extra stage over RD_LAT covers the issue register in front of the BRAM.
  bram_rd_tag_pipe #(.DEPTH(RD_LAT + 1)) u_tag_pipe (
    .clock     (clock),
    .reset     (reset),
    .in_valid  (accept & ~win_we),
    .in_id     (win_id),
    .out_valid (tag_out_valid),
    .out_id    (tag_out_id),
    .any_valid (tag_busy)
  );

  assign req0_ready = grant0;
  assign req1_ready = grant1;
  assign bram_ena   = ena_q;
  assign bram_wea   = wea_q;
  assign bram_addra = addr_q;
  assign bram_dina  = din_q;
  assign rsp0_valid = rsp0_valid_q;
  assign rsp1_valid = rsp1_valid_q;
  assign rsp0_rdata = rsp0_rdata_q;
  assign rsp1_rdata = rsp1_rdata_q;
  assign busy       = tag_busy | ena_q;

endmodule

// File: tb/tb_bram_port_arbiter.sv
// Bench for bram_port_arbiter: BRAM model, transaction-level reference model,
// an arbitration vector table, directed corner sequences and random traffic.
module tb_bram_port_arbiter;
  import ising_bram_pkg::*;
  localparam int DW  = DATA_W;
  localparam int AW  = ADDR_W;
  localparam int LAT = RD_LAT;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          req0_valid = 1'b0, req0_we = 1'b0;
  logic [AW-1:0] req0_addr = '0;
  logic [DW-1:0] req0_wdata = '0;
  logic          req1_valid = 1'b0, req1_we = 1'b0;
  logic [AW-1:0] req1_addr = '0;
  logic [DW-1:0] req1_wdata = '0;
  logic          req0_ready, req1_ready, rsp0_valid, rsp1_valid;
  logic [DW-1:0] rsp0_rdata, rsp1_rdata;
  logic          bram_ena, bram_wea, busy;
  logic [AW-1:0] bram_addra;
  logic [DW-1:0] bram_dina, bram_douta;

  always #5 clock = ~clock;

  bram_port_arbiter dut (
    .clock(clock), .reset(reset),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_we(req0_we),
    .req0_addr(req0_addr), .req0_wdata(req0_wdata),
    .rsp0_valid(rsp0_valid), .rsp0_rdata(rsp0_rdata),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_we(req1_we),
    .req1_addr(req1_addr), .req1_wdata(req1_wdata),
    .rsp1_valid(rsp1_valid), .rsp1_rdata(rsp1_rdata),
    .bram_ena(bram_ena), .bram_wea(bram_wea), .bram_addra(bram_addra),
    .bram_dina(bram_dina), .bram_douta(bram_douta), .busy(busy)
  );

  // BRAM model: samples addr on the edge after issue, output register adds one more clock.
  logic [DW-1:0] mem [128];
  logic [DW-1:0] ram_q = '0, douta_q = '0;
  logic          pre_we = 1'b0;
  logic [AW-1:0] pre_addr = '0;
  logic [DW-1:0] pre_data = '0;
  always @(posedge clock) begin
    if (pre_we) mem[pre_addr] <= pre_data;
    else if (bram_ena) begin
      if (bram_wea) mem[bram_addra] <= bram_dina;
      else ram_q <= mem[bram_addra];
    end
    douta_q <= ram_q;
  end
  assign bram_douta = douta_q;

  // Reference model: memory image updated in acceptance order, queue of due responses.
  typedef struct { int id; logic [DW-1:0] data; int due; } exp_t;
  logic [DW-1:0] shadow [128];
  exp_t          expq [$];
  int            acc_log [$];
  int            rr_m = 0, cyc = 0, last_acc_cyc = 0;
  logic [DW-1:0] exp_rd0 = '0, exp_rd1 = '0;
  int            rsp_cnt [2];
  int            last_rsp_cyc [2];
  logic          last_g0 = 1'b0, last_g1 = 1'b0;
  int            checks = 0, failures = 0;

  task automatic chk1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0b expected %0b (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic chk64(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic chki(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic set0(input logic v, input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d);
    req0_valid = v; req0_we = we; req0_addr = a; req0_wdata = d;
  endtask

  task automatic set1(input logic v, input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d);
    req1_valid = v; req1_we = we; req1_addr = a; req1_wdata = d;
  endtask

  task automatic tick();
    logic g0, g1, acc, wwe, ev0, ev1;
    logic [AW-1:0] wa;
    logic [DW-1:0] wd;
    int wid;
    exp_t e;
    #1;
    g0 = req0_valid && (!req1_valid || rr_m == 0);
    g1 = req1_valid && (!req0_valid || rr_m == 1);
    chk1("req0_ready", req0_ready, g0);
    chk1("req1_ready", req1_ready, g1);
    wid = g1 ? 1 : 0;
    wwe = g1 ? req1_we : req0_we;
    wa  = g1 ? req1_addr : req0_addr;
    wd  = g1 ? req1_wdata : req0_wdata;
    acc = g0 | g1;
    @(posedge clock);
    cyc++;
    last_g0 = g0; last_g1 = g1;
    if (acc) begin
      if (wwe) shadow[wa] = wd;
      else begin
        e.id = wid; e.data = shadow[wa]; e.due = cyc + LAT + 1;
        expq.push_back(e);
      end
      rr_m = 1 - wid;
      acc_log.push_back(wid);
      last_acc_cyc = cyc;
    end
    #1;
    chk1("bram_ena", bram_ena, acc);
    chk1("bram_wea", bram_wea, acc & wwe);
    if (acc) begin
      chk64("bram_addra", DW'(bram_addra), DW'(wa));
      chk64("bram_dina", bram_dina, wd);
    end
    ev0 = 1'b0; ev1 = 1'b0;
    if (expq.size() > 0 && expq[0].due == cyc) begin
      e = expq.pop_front();
      if (e.id == 0) begin ev0 = 1'b1; exp_rd0 = e.data; end
      else begin ev1 = 1'b1; exp_rd1 = e.data; end
    end
    chk1("rsp0_valid", rsp0_valid, ev0);
    chk1("rsp1_valid", rsp1_valid, ev1);
    chk64("rsp0_rdata", rsp0_rdata, exp_rd0);
    chk64("rsp1_rdata", rsp1_rdata, exp_rd1);
    chk1("busy", busy, (expq.size() > 0) || acc);
    if (rsp0_valid) begin rsp_cnt[0]++; last_rsp_cyc[0] = cyc; end
    if (rsp1_valid) begin rsp_cnt[1]++; last_rsp_cyc[1] = cyc; end
  endtask

  task automatic check_reset_state(input string tag);
    chk1({tag, "_req0_ready"}, req0_ready, 1'b0);
    chk1({tag, "_req1_ready"}, req1_ready, 1'b0);
    chk1({tag, "_bram_ena"}, bram_ena, 1'b0);
    chk1({tag, "_bram_wea"}, bram_wea, 1'b0);
    chk64({tag, "_bram_addra"}, DW'(bram_addra), '0);
    chk64({tag, "_bram_dina"}, bram_dina, '0);
    chk1({tag, "_rsp0_valid"}, rsp0_valid, 1'b0);
    chk1({tag, "_rsp1_valid"}, rsp1_valid, 1'b0);
    chk64({tag, "_rsp0_rdata"}, rsp0_rdata, '0);
    chk64({tag, "_rsp1_rdata"}, rsp1_rdata, '0);
    chk1({tag, "_busy"}, busy, 1'b0);
  endtask

  task automatic do_reset();
    set0(0, 0, '0, '0); set1(0, 0, '0, '0);
    reset = 1'b1;
    #1;
    expq.delete();
    rr_m = 0; exp_rd0 = '0; exp_rd1 = '0;
    check_reset_state("midrst");
    @(posedge clock);
    #1;
    reset = 1'b0;
    cyc++;
    chk1("busy_after_reset", busy, 1'b0);
  endtask

  typedef struct { logic v0; cmd_t c0; logic v1; cmd_t c1; logic r0; logic r1; } vec_t;

  function automatic vec_t mk(input logic v0, input logic we0, input int a0, input int d0,
                              input logic v1, input logic we1, input int a1, input int d1,
                              input logic r0, input logic r1);
    vec_t t;
    t.v0 = v0; t.c0.we = we0; t.c0.addr = AW'(a0); t.c0.wdata = DW'(d0);
    t.v1 = v1; t.c1.we = we1; t.c1.addr = AW'(a1); t.c1.wdata = DW'(d1);
    t.r0 = r0; t.r1 = r1;
    return t;
  endfunction

  vec_t tbl [16];

  initial begin
    int base, rdy_cnt, alt_err, n0, n1, rd_acc;
    logic [DW-1:0] d;
    rsp_cnt[0] = 0; rsp_cnt[1] = 0; last_rsp_cyc[0] = 0; last_rsp_cyc[1] = 0;

    // Preload the whole BRAM (and the model image) while reset is held.
    for (int i = 0; i < 130; i++) begin
      pre_addr = (i == 128) ? AW'(4) : (i == 129) ? AW'(8) : AW'(i);
      d = (i == 128) ? 64'h23 : (i == 129) ? 64'h88 : {$urandom, $urandom};
      pre_data = d; pre_we = 1'b1;
      shadow[pre_addr] = d;
      @(posedge clock);
      #1;
    end
    pre_we = 1'b0;
    check_reset_state("reset");
    reset = 1'b0;

    // Arbitration table; rows 0-1 are the reset contention case (req0 then req1).
    tbl[0]  = mk(1, 0, 4, 0,     1, 0, 8, 0,     1, 0);
    tbl[1]  = mk(0, 0, 0, 0,     1, 0, 8, 0,     0, 1);
    tbl[2]  = mk(0, 0, 0, 0,     0, 0, 0, 0,     0, 0);
    tbl[3]  = mk(1, 1, 20, 'hA0, 1, 1, 21, 'hB1, 1, 0);
    tbl[4]  = mk(1, 1, 22, 'hA2, 1, 1, 21, 'hB1, 0, 1);
    tbl[5]  = mk(1, 1, 22, 'hA2, 1, 0, 20, 0,    1, 0);
    tbl[6]  = mk(0, 0, 0, 0,     1, 0, 20, 0,    0, 1);
    tbl[7]  = mk(1, 0, 21, 0,    0, 0, 0, 0,     1, 0);
    tbl[8]  = mk(1, 0, 22, 0,    0, 0, 0, 0,     1, 0);
    tbl[9]  = mk(1, 0, 4, 0,     1, 0, 8, 0,     0, 1);
    tbl[10] = mk(1, 0, 4, 0,     0, 0, 0, 0,     1, 0);
    for (int i = 11; i < 16; i++) tbl[i] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 16; i++) begin
      set0(tbl[i].v0, tbl[i].c0.we, tbl[i].c0.addr, tbl[i].c0.wdata);
      set1(tbl[i].v1, tbl[i].c1.we, tbl[i].c1.addr, tbl[i].c1.wdata);
      #1;
      chk1($sformatf("tbl%0d_r0", i), req0_ready, tbl[i].r0);
      chk1($sformatf("tbl%0d_r1", i), req1_ready, tbl[i].r1);
      tick();
      if (i == 4) chk64("contention_rsp0", rsp0_rdata, 64'h23);
      if (i == 5) chk64("contention_rsp1", rsp1_rdata, 64'h88);
      if (i == 9) chk64("tbl_rsp1_raw", rsp1_rdata, 64'hA0);
    end

    // Single write then read on req0.
    base = rsp_cnt[1];
    set0(1, 1, 4, 64'h23); tick();
    set0(1, 0, 4, '0); tick();
    rd_acc = last_acc_cyc;
    set0(0, 0, '0, '0);
    repeat (5) tick();
    chki("single_latency", last_rsp_cyc[0] - rd_acc, LAT + 1);
    chk64("single_rdata", rsp0_rdata, 64'h23);
    chki("single_no_rsp1", rsp_cnt[1] - base, 0);

    // Streaming on req1: 8 writes then 8 reads back to back.
    rdy_cnt = 0; base = rsp_cnt[1];
    for (int i = 0; i < 16; i++) begin
      if (i < 8) set1(1, 1, AW'(i), DW'(8'h10 + i));
      else set1(1, 0, AW'(i - 8), '0);
      #1;
      if (req1_ready) rdy_cnt++;
      tick();
    end
    rd_acc = last_acc_cyc;
    set1(0, 0, '0, '0);
    repeat (5) tick();
    chki("stream_ready_cycles", rdy_cnt, 16);
    chki("stream_rsp_count", rsp_cnt[1] - base, 8);
    chki("stream_last_latency", last_rsp_cyc[1] - rd_acc, LAT + 1);
    chk64("stream_last_rdata", rsp1_rdata, 64'h17);

    // Fairness: both valid for 20 cycles.
    acc_log.delete();
    set0(1, 0, 1, '0); set1(1, 0, 2, '0);
    repeat (20) tick();
    set0(0, 0, '0, '0); set1(0, 0, '0, '0);
    n0 = 0; n1 = 0; alt_err = 0;
    for (int i = 0; i < acc_log.size(); i++) begin
      if (acc_log[i] == 0) n0++; else n1++;
      if (i > 0 && acc_log[i] == acc_log[i-1]) alt_err++;
    end
    chki("fair_req0", n0, 10);
    chki("fair_req1", n1, 10);
    chki("fair_alternation", alt_err, 0);
    repeat (4) tick();

    // Read-after-write across requesters.
    set0(1, 1, 8, 64'h55); tick();
    set0(1, 1, 8, 64'h88); tick();
    set0(0, 0, '0, '0); set1(1, 0, 8, '0); tick();
    set1(0, 0, '0, '0);
    repeat (4) tick();
    chk64("raw_rsp1", rsp1_rdata, 64'h88);

    // Reset one edge after a read is accepted.
    base = rsp_cnt[0] + rsp_cnt[1];
    set0(1, 0, 4, '0); tick();
    set0(0, 0, '0, '0); tick();
    do_reset();
    repeat (6) tick();
    chki("reset_no_rsp", rsp_cnt[0] + rsp_cnt[1] - base, 0);
    d = shadow[4];
    set0(1, 0, 4, '0); tick();
    set0(0, 0, '0, '0);
    repeat (4) tick();
    chk64("post_reset_read", rsp0_rdata, d);

    // Random traffic, holding each command until it is accepted.
    last_g0 = 1'b0; last_g1 = 1'b0;
    for (int n = 0; n < 400; n++) begin
      if (!req0_valid || last_g0) begin
        if ($urandom_range(0, 3) != 0)
          set0(1, 1'($urandom_range(0, 1)), AW'($urandom_range(0, 15)), {$urandom, $urandom});
        else set0(0, 0, '0, '0);
      end
      if (!req1_valid || last_g1) begin
        if ($urandom_range(0, 3) != 0)
          set1(1, 1'($urandom_range(0, 1)), AW'($urandom_range(0, 15)), {$urandom, $urandom});
        else set1(0, 0, '0, '0);
      end
      tick();
    end
    set0(0, 0, '0, '0); set1(0, 0, '0, '0);
    repeat (6) tick();
    chki("final_queue_empty", expq.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/bram_port_arbiter.md
Name: bram_port_arbiter

Overview:
- Shares one single-port 64x128 block RAM (design_1_blk_mem_gen_0_0, output register enabled via regcea) between two requesters: req0 is the spin-update engine and req1 is the host/config loader.
- Each requester issues reads and writes through a valid/ready handshake.
- The arbiter serialises the requests onto the BRAM port and routes each read result back to the requester that issued it, after a fixed latency.
- Sits directly between the sampler datapath and the BRAM instance.

Parameters:
- DATA_W, 64, BRAM data width.
- ADDR_W, 7, BRAM address width (128 words).
- RD_LAT, 2, BRAM read latency in clocks from the addr-sampling edge to valid douta (2 with regcea=1).

Ports:
- clock  in  1  system clock; all logic on posedge.
- reset  in  1  asynchronous, active-high; clears all state.
- req0_valid  in  1  requester 0 has a command.
- req0_ready  out  1  arbiter accepts the req0 command this cycle.
- req0_we  in  1  1=write, 0=read.
- req0_addr  in  ADDR_W  word address.
- req0_wdata  in  DATA_W  write data.
- rsp0_valid  out  1  one-cycle pulse: rsp0_rdata holds read data.
- rsp0_rdata  out  DATA_W  read data for req0.
- req1_valid, req1_ready, req1_we, req1_addr, req1_wdata, rsp1_valid, rsp1_rdata: same as the req0/rsp0 set, for requester 1.
- bram_ena  out  1  to BRAM ena.
- bram_wea  out  1  to BRAM wea.
- bram_addra  out  ADDR_W  to BRAM addra.
- bram_dina  out  DATA_W  to BRAM dina.
- bram_douta  in  DATA_W  from BRAM douta.
- busy  out  1  high while any read is in flight or an issue is pending.

Behaviour:
- Reset values: all ready/valid outputs 0; bram_ena=0, bram_wea=0; bram_addra=0, bram_dina=0, rsp*_rdata=0; busy=0; round-robin pointer = "req0 next".
- Handshake:
  - reqN_ready is combinational from the valids and the rr pointer; at most one ready is high per cycle.
  - A command is accepted on the edge where valid&ready=1.
  - A requester must hold its valid, we, addr and wdata stable until accepted.
  - Ready never depends on the requester's own ready.
- Arbitration:
  - Only one valid: that requester gets ready every cycle, giving 1 command/clock throughput.
  - Both valid: the requester indicated by the rr pointer wins; the pointer then moves to the other requester.
  - The pointer updates only on acceptance.
- Issue stage:
  - On the acceptance edge E0, bram_ena/wea/addra/dina are registered from the winner.
  - With no acceptance, bram_ena=0 and bram_wea=0 next cycle; addr and din hold their value.
  - The BRAM samples at E1.
- Reads:
  - A tag {valid, id} enters a shift register of depth RD_LAT+1 at E0.
  - At edge E0+RD_LAT+1, bram_douta is captured into rspN_rdata (N = tag id) and rspN_valid pulses high for exactly one cycle.
  - With the defaults, rsp is visible in the cycle after the 3rd edge following acceptance.
  - The other rsp_rdata holds its value.
- Writes:
  - No response is generated.
  - A read accepted on any later edge returns the new data, because BRAM order equals acceptance order.
- Ordering: responses per requester arrive strictly in acceptance order. Interleaved reads from both requesters return on consecutive cycles, matching the issue order.
- Back-to-back and mixed read/write traffic:
  - No bubbles are required.
  - No hazard exists because the BRAM has a single port and a fixed pipeline.
- Reset mid-operation:
  - All in-flight tags are dropped; no rsp pulse follows reset deassertion.
  - The BRAM contents are not cleared.
- busy = |tag_pipe valid bits | bram_ena.

Decomposition:
- Shared package (ising_bram_pkg):
  - DATA_W, ADDR_W and RD_LAT constants.
  - Requester-id typedef (1 bit; REQ_SPIN=0, REQ_HOST=1).
  - Command struct {we, addr, wdata}.
- Sub-module bram_rd_tag_pipe: parameterised-depth shift register of {valid, id} with async reset. It outputs the tag aligned to douta capture.

Test Plan:
- Single write/read: req0 writes 0x23 to addr 4, then reads addr 4 → bram_ena/wea=1 one cycle after acceptance; rsp0_valid pulses RD_LAT+1 edges after the read acceptance with rsp0_rdata=0x23; rsp1_valid stays 0.
- Contention: req0 and req1 both hold valid reads (addr 4, addr 8; the BRAM is preloaded with 0x23 and 0x88) from reset → grants go req0, then req1; rsp0=0x23 and rsp1=0x88 on consecutive cycles.
- Streaming: req1 alone issues 8 back-to-back writes (addr 0..7, data 0x10+addr), then 8 reads → req1_ready stays high for 16 cycles; the reads return 0x10..0x17 on 8 consecutive rsp1_valid cycles.
- Fairness: both requesters are continuously valid for 20 cycles → exactly 10 acceptances each, strictly alternating.
- Read-after-write: req0 writes 0x88 to addr 8 in the cycle immediately before req1 reads addr 8 → rsp1_rdata=0x88.
- Reset mid-flight: reset is asserted for 1 cycle, 1 edge after a read is accepted → no rsp pulse, busy=0 after reset; a subsequent read returns the correct data.
